// File: rtl/seg_disp_ctrl.sv
// Command-driven register file for the 8-digit 74HC595 segment scanner.
// Holds digit values and enable/dot/blink masks; blinking digits are gated by a half-period timer.
module seg_disp_ctrl #(
  parameter int unsigned BLINK_HALF = 6000000,
  parameter int          CNT_W      = 24
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [2:0] cmd_op,
  input  logic [2:0] cmd_addr,
  input  logic [7:0] cmd_data,
  output logic [3:0] dat_1,
  output logic [3:0] dat_2,
  output logic [3:0] dat_3,
  output logic [3:0] dat_4,
  output logic [3:0] dat_5,
  output logic [3:0] dat_6,
  output logic [3:0] dat_7,
  output logic [3:0] dat_8,
  output logic [7:0] dat_en,
  output logic [7:0] dot_en,
  output logic       blink_phase
);

  localparam logic [2:0] OP_WR_DIGIT  = 3'd1;
  localparam logic [2:0] OP_SET_EN    = 3'd2;
  localparam logic [2:0] OP_SET_DOT   = 3'd3;
  localparam logic [2:0] OP_SET_BLINK = 3'd4;
  localparam logic [2:0] OP_CLEAR     = 3'd5;
  localparam logic [2:0] OP_SHIFT_IN  = 3'd6;

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BLINK_HALF - 1);

  typedef enum logic {IDLE, CLR} state_t;

  state_t           state, state_nxt;
  logic [2:0]       idx, idx_nxt;
  logic [3:0]       digit [8];
  logic [7:0]       en_reg, dot_reg, blink_mask;
  logic [CNT_W-1:0] blink_cnt;
  logic             accept;

  assign cmd_ready = (state == IDLE);
  assign accept    = cmd_valid & cmd_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      idx   <= 3'd0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      IDLE: begin
        if (accept && cmd_op == OP_CLEAR) begin
          state_nxt = CLR;
          idx_nxt   = 3'd0;
        end
      end
      CLR: begin
        idx_nxt = idx + 3'd1;
        if (idx == 3'd7) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Digit index i maps to bit 7-i of the masks, i.e. bit ~i for a 3-bit index.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < 8; i++) digit[i] <= 4'h0;
      en_reg     <= 8'h00;
      dot_reg    <= 8'h00;
      blink_mask <= 8'h00;
    end else if (state == CLR) begin
      digit[idx]    <= 4'h0;
      en_reg[~idx]  <= 1'b0;
      dot_reg[~idx] <= 1'b0;
      if (idx == 3'd7) blink_mask <= 8'h00;
    end else if (accept) begin
      case (cmd_op)
        OP_WR_DIGIT: begin
          digit[cmd_addr]    <= cmd_data[3:0];
          dot_reg[~cmd_addr] <= cmd_data[4];
          en_reg[~cmd_addr]  <= cmd_data[5];
        end
        OP_SET_EN:    en_reg     <= cmd_data;
        OP_SET_DOT:   dot_reg    <= cmd_data;
        OP_SET_BLINK: blink_mask <= cmd_data;
        OP_SHIFT_IN: begin
          for (int i = 0; i < 7; i++) digit[i] <= digit[i+1];
          digit[7] <= cmd_data[3:0];
          en_reg   <= {en_reg[6:0], 1'b1};
          dot_reg  <= {dot_reg[6:0], cmd_data[4]};
        end
        default: ;
      endcase
    end
  end

  // A SET_BLINK restarts the half-period so the blink pattern begins in the visible phase.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (accept && cmd_op == OP_SET_BLINK) begin
      blink_cnt   <= '0;
      blink_phase <= 1'b0;
    end else if (blink_cnt == CNT_LAST) begin
      blink_cnt   <= '0;
      blink_phase <= ~blink_phase;
    end else begin
      blink_cnt <= blink_cnt + CNT_W'(1);
    end
  end

  assign dat_1  = digit[0];
  assign dat_2  = digit[1];
  assign dat_3  = digit[2];
  assign dat_4  = digit[3];
  assign dat_5  = digit[4];
  assign dat_6  = digit[5];
  assign dat_7  = digit[6];
  assign dat_8  = digit[7];
  assign dat_en = en_reg & ~(blink_mask & {8{blink_phase}});
  assign dot_en = dot_reg;

endmodule

// File: tb/tb_seg_disp_ctrl.sv
// Bench for seg_disp_ctrl: table-driven command vectors through a scoreboard queue,
// plus hand sequences for blinking, the CLEAR sweep and reset during a sweep.
module tb_seg_disp_ctrl;

  localparam logic [2:0] OP_NOP   = 3'd0;
  localparam logic [2:0] OP_WR    = 3'd1;
  localparam logic [2:0] OP_EN    = 3'd2;
  localparam logic [2:0] OP_DOT   = 3'd3;
  localparam logic [2:0] OP_BLINK = 3'd4;
  localparam logic [2:0] OP_CLEAR = 3'd5;
  localparam logic [2:0] OP_SHIFT = 3'd6;
  localparam logic [2:0] OP_RSVD  = 3'd7;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [2:0] cmd_op;
  logic [2:0] cmd_addr;
  logic [7:0] cmd_data;
  logic [3:0] dat_1, dat_2, dat_3, dat_4, dat_5, dat_6, dat_7, dat_8;
  logic [7:0] dat_en, dot_en;
  logic       blink_phase;
  logic [31:0] dat_vec;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        rst;
    logic [2:0]  op;
    logic [2:0]  addr;
    logic [7:0]  data;
    logic [31:0] dat;
    logic [7:0]  en;
    logic [7:0]  dot;
  } vec_t;

  typedef struct {
    logic [31:0] dat;
    logic [7:0]  en;
    logic [7:0]  dot;
  } exp_t;

  vec_t vecs [16];
  exp_t sb [$];

  seg_disp_ctrl #(.BLINK_HALF(4), .CNT_W(24)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_op(cmd_op), .cmd_addr(cmd_addr), .cmd_data(cmd_data),
    .dat_1(dat_1), .dat_2(dat_2), .dat_3(dat_3), .dat_4(dat_4),
    .dat_5(dat_5), .dat_6(dat_6), .dat_7(dat_7), .dat_8(dat_8),
    .dat_en(dat_en), .dot_en(dot_en), .blink_phase(blink_phase)
  );

  assign dat_vec = {dat_1, dat_2, dat_3, dat_4, dat_5, dat_6, dat_7, dat_8};

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: sim time exceeded, total=%0d", total);
    $fatal(1, "watchdog");
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic check_sb(input string name);
    exp_t e;
    if (sb.size() == 0) begin
      total++;
      bad++;
      $display("FAIL %s: scoreboard empty, got dat=%h want an entry", name, dat_vec);
    end else begin
      e = sb.pop_front();
      chk({name, "_dat"}, dat_vec, e.dat);
      chk({name, "_en"}, 32'(dat_en), 32'(e.en));
      chk({name, "_dot"}, 32'(dot_en), 32'(e.dot));
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  // Returns 1 ns after the accepting edge with cmd_valid dropped.
  task automatic send(input logic [2:0] op, input logic [2:0] addr, input logic [7:0] data);
    int n;
    cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_valid = 1'b1;
    n = 0;
    while (!cmd_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (!cmd_ready) begin
      total++;
      bad++;
      $display("FAIL send_timeout: ready=%b want 1", cmd_ready);
      cmd_valid = 1'b0;
    end else begin
      @(posedge clk);
      #1;
      cmd_valid = 1'b0;
      cmd_op    = OP_NOP;
    end
  endtask

  initial begin
    int low_cnt;
    logic [7:0] exp_en;

    vecs[0]  = '{1'b0, OP_WR,    3'd0, 8'h3A, 32'hA000_0000, 8'h80, 8'h80};
    vecs[1]  = '{1'b0, OP_WR,    3'd7, 8'h25, 32'hA000_0005, 8'h81, 8'h80};
    vecs[2]  = '{1'b0, OP_EN,    3'd4, 8'hFF, 32'hA000_0005, 8'hFF, 8'h80};
    vecs[3]  = '{1'b0, OP_DOT,   3'd1, 8'h0F, 32'hA000_0005, 8'hFF, 8'h0F};
    vecs[4]  = '{1'b0, OP_NOP,   3'd2, 8'hAA, 32'hA000_0005, 8'hFF, 8'h0F};
    vecs[5]  = '{1'b0, OP_RSVD,  3'd3, 8'h55, 32'hA000_0005, 8'hFF, 8'h0F};
    vecs[6]  = '{1'b0, OP_WR,    3'd3, 8'hC7, 32'hA007_0005, 8'hEF, 8'h0F};
    vecs[7]  = '{1'b1, OP_SHIFT, 3'd5, 8'h01, 32'h0000_0001, 8'h01, 8'h00};
    vecs[8]  = '{1'b0, OP_SHIFT, 3'd0, 8'h12, 32'h0000_0012, 8'h03, 8'h01};
    vecs[9]  = '{1'b0, OP_SHIFT, 3'd7, 8'h03, 32'h0000_0123, 8'h07, 8'h02};
    vecs[10] = '{1'b0, OP_SHIFT, 3'd2, 8'h04, 32'h0000_1234, 8'h0F, 8'h04};
    vecs[11] = '{1'b0, OP_SHIFT, 3'd1, 8'h05, 32'h0001_2345, 8'h1F, 8'h08};
    vecs[12] = '{1'b0, OP_SHIFT, 3'd6, 8'h06, 32'h0012_3456, 8'h3F, 8'h10};
    vecs[13] = '{1'b0, OP_SHIFT, 3'd3, 8'h07, 32'h0123_4567, 8'h7F, 8'h20};
    vecs[14] = '{1'b0, OP_SHIFT, 3'd4, 8'h08, 32'h1234_5678, 8'hFF, 8'h40};
    vecs[15] = '{1'b0, OP_SHIFT, 3'd0, 8'h09, 32'h2345_6789, 8'hFF, 8'h80};

    cmd_valid = 1'b0; cmd_op = OP_NOP; cmd_addr = 3'd0; cmd_data = 8'h00;
    do_reset();
    repeat (3) @(negedge clk);
    chk("rst_dat", dat_vec, 32'h0);
    chk("rst_en", 32'(dat_en), 32'h0);
    chk("rst_dot", 32'(dot_en), 32'h0);
    chk("rst_ready", 32'(cmd_ready), 32'h1);
    chk("rst_phase", 32'(blink_phase), 32'h0);

    foreach (vecs[i]) begin
      if (vecs[i].rst) do_reset();
      sb.push_back('{vecs[i].dat, vecs[i].en, vecs[i].dot});
      send(vecs[i].op, vecs[i].addr, vecs[i].data);
      @(negedge clk);
      check_sb($sformatf("vec%0d", i));
    end

    // Blink: SEG1 and SEG8 blink with a 4-cycle half-period.
    do_reset();
    send(OP_EN, 3'd0, 8'hFF);
    send(OP_BLINK, 3'd0, 8'h81);
    for (int k = 0; k < 16; k++) begin
      @(negedge clk);
      exp_en = (((k / 4) % 2) == 1) ? 8'h7E : 8'hFF;
      chk($sformatf("blink_en%0d", k), 32'(dat_en), 32'(exp_en));
      chk($sformatf("blink_ph%0d", k), 32'(blink_phase), ((k / 4) % 2));
      chk($sformatf("blink_dot%0d", k), 32'(dot_en), 32'h0);
    end

    // CLEAR sweep with a WR_DIGIT held behind it.
    do_reset();
    for (int k = 0; k < 8; k++) send(OP_SHIFT, 3'd0, 8'h19);
    send(OP_BLINK, 3'd0, 8'h01);
    send(OP_CLEAR, 3'd0, 8'h00);
    cmd_op = OP_WR; cmd_addr = 3'd2; cmd_data = 8'h34; cmd_valid = 1'b1;
    low_cnt = 0;
    for (int k = 0; k <= 8; k++) begin
      @(negedge clk);
      if (!cmd_ready) low_cnt++;
      chk($sformatf("clr_rdy%0d", k), 32'(cmd_ready), (k == 8) ? 32'h1 : 32'h0);
      chk($sformatf("clr_en%0d", k), 32'(dat_en & 8'hFE), 32'((8'hFF >> k) & 8'hFE));
      chk($sformatf("clr_dot%0d", k), 32'(dot_en), 32'(8'hFF >> k));
      chk($sformatf("clr_dat%0d", k), dat_vec, 32'h9999_9999 >> (4 * k));
    end
    chk("clr_low_cycles", 32'(low_cnt), 32'd8);
    sb.push_back('{32'h0040_0000, 8'h20, 8'h20});
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
    cmd_op    = OP_NOP;
    @(negedge clk);
    check_sb("held_wr");

    // Blink mask must have been cleared by the sweep.
    send(OP_EN, 3'd0, 8'hFF);
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("mask_clr%0d", k), 32'(dat_en), 32'hFF);
    end

    // Reset asserted while the sweep is at index 3.
    send(OP_CLEAR, 3'd0, 8'h00);
    repeat (3) @(posedge clk);
    #2;
    chk("mid_clr_en", 32'(dat_en), 32'h1F);
    rst_n = 1'b0;
    #1;
    chk("arst_dat", dat_vec, 32'h0);
    chk("arst_en", 32'(dat_en), 32'h0);
    chk("arst_dot", 32'(dot_en), 32'h0);
    chk("arst_ready", 32'(cmd_ready), 32'h1);
    chk("arst_phase", 32'(blink_phase), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    chk("post_rst_ready", 32'(cmd_ready), 32'h1);
    sb.push_back('{32'h0000_0F00, 8'h04, 8'h00});
    send(OP_WR, 3'd5, 8'h2F);
    @(negedge clk);
    check_sb("post_rst_wr");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
